// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/allow interlock, ready_go stall,
// flush and exception-bubble capture. With SKID_EN=1 a second entry absorbs
// the beat that arrives while downstream stalls, so up_allow depends only on
// registered state and the comb allow chain between stages is cut.
module pipe_stage_skid #(
    parameter int unsigned       DATA_W      = 64,
    parameter int unsigned       MSG_W       = 32,
    parameter bit                SKID_EN     = 1'b1,
    parameter logic [DATA_W-1:0] RESET_VALUE = '0,
    parameter logic [DATA_W-1:0] NOP_VALUE   = '0,
    parameter bit                IS_PC       = 1'b0
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [MSG_W-1:0]  in_msg,
    input  logic              in_exc,
    output logic              up_allow,
    input  logic              ready_go,
    input  logic              down_allow,
    input  logic              flush,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [MSG_W-1:0]  out_msg,
    output logic [1:0]        occupancy
);

    // State encodes {head_v, skid_v}; FULL is only reachable with SKID_EN=1.
    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StOne   = 2'b10,
        StFull  = 2'b11
    } state_e;

    state_e            state_q;
    logic [DATA_W-1:0] head_data_q;
    logic [MSG_W-1:0]  head_msg_q;
    logic [DATA_W-1:0] skid_data_q;
    logic [MSG_W-1:0]  skid_msg_q;

    logic              head_v;
    logic              skid_v;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] cap_data;

    assign head_v = (state_q != StEmpty);
    assign skid_v = (state_q == StFull);

    assign out_valid = head_v && ready_go;
    assign pop       = out_valid && down_allow;
    assign push      = in_valid && up_allow;

    // An exception bubble keeps its message but scrubs the payload.
    assign cap_data = in_exc ? RESET_VALUE : in_data;

    // Upstream allow: registered-only in skid mode, comb pass-through otherwise.
    always_comb begin
        up_allow = 1'b0;
        if (SKID_EN) begin
            up_allow = !skid_v;
        end else begin
            up_allow = !head_v || pop;
        end
    end

    // Entry FSM and payload storage; flush discards everything.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= StEmpty;
            head_data_q <= RESET_VALUE;
            head_msg_q  <= '0;
            skid_data_q <= RESET_VALUE;
            skid_msg_q  <= '0;
        end else if (flush) begin
            state_q     <= StEmpty;
            head_data_q <= RESET_VALUE;
            head_msg_q  <= '0;
            skid_data_q <= RESET_VALUE;
            skid_msg_q  <= '0;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (push) begin
                        head_data_q <= cap_data;
                        head_msg_q  <= in_msg;
                        state_q     <= StOne;
                    end
                end
                StOne: begin
                    if (push && pop) begin
                        head_data_q <= cap_data;
                        head_msg_q  <= in_msg;
                    end else if (push) begin
                        // Only reachable in skid mode: comb allow forbids it otherwise.
                        skid_data_q <= cap_data;
                        skid_msg_q  <= in_msg;
                        state_q     <= StFull;
                    end else if (pop) begin
                        state_q <= StEmpty;
                    end
                end
                StFull: begin
                    if (pop) begin
                        head_data_q <= skid_data_q;
                        head_msg_q  <= skid_msg_q;
                        state_q     <= StOne;
                    end
                end
                default: begin
                    state_q <= StEmpty;
                end
            endcase
        end
    end

    // Head entry drives the outputs; PC stage exposes its register even when invalid.
    always_comb begin
        out_data = NOP_VALUE;
        out_msg  = '0;
        if (head_v || IS_PC) begin
            out_data = head_data_q;
        end
        if (head_v) begin
            out_msg = head_msg_q;
        end
    end

    // Entry count derived from the state encoding.
    always_comb begin
        occupancy = 2'd0;
        case (state_q)
            StEmpty: occupancy = 2'd0;
            StOne:   occupancy = 2'd1;
            StFull:  occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    a_no_push_full : assert property (@(posedge aclk) disable iff (!aresetn)
        (state_q == StFull) |-> !push);

    a_occ_count : assert property (@(posedge aclk) disable iff (!aresetn)
        occupancy == ({1'b0, head_v} + {1'b0, skid_v}));

    a_no_x_out : assert property (@(posedge aclk) disable iff (!aresetn)
        !$isunknown({out_valid, out_data, out_msg, occupancy, up_allow}));

endmodule
